// File: rtl/idelay_pkg.sv
// Shared types and constants for the idelaye3_asic tap-delay block.
// Holds tap width, delay-line depth, mode enums and the update FSM states.
package idelay_pkg;

    localparam int TAP_W      = 9;
    localparam int LINE_DEPTH = 16;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        DT_FIXED,
        DT_VARIABLE,
        DT_VAR_LOAD
    } delay_type_e;

    typedef enum logic {
        UM_ASYNC,
        UM_SYNC
    } update_mode_e;

    typedef enum logic {
        SRC_IDATAIN,
        SRC_DATAIN
    } delay_src_e;

    typedef enum logic {
        ST_IDLE,
        ST_ARMED
    } upd_state_e;

    // One tap step with natural modulo-512 wrap in both directions.
    function automatic logic [TAP_W-1:0] tap_step(
        input logic [TAP_W-1:0] t,
        input logic             inc
    );
        return inc ? t + TAP_W'(1) : t - TAP_W'(1);
    endfunction

endpackage

// File: rtl/idelay_line.sv
// Delay line: 16-entry sample shift register with a registered tap mux.
// Ports: CLK, RST_N, src (serial in), idx (tap index), dout, src_edge.
module idelay_line
    import idelay_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             src,
    input  logic [IDX_W-1:0] idx,
    output logic             dout,
    output logic             src_edge
);

    logic [LINE_DEPTH-1:0] sr;

    // High when the sample about to be taken differs from the last one.
    assign src_edge = src ^ sr[0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr   <= '0;
            dout <= 1'b0;
        end else begin
            sr   <= {sr[LINE_DEPTH-2:0], src};
            dout <= sr[idx];
        end
    end

endmodule

// File: rtl/idelaye3_asic.sv
// Tap-controlled data delay: tap control, ASYNC/SYNC commit FSM, delay line.
// Ports: CLK, RST_N, IDATAIN, DATAIN, CE, INC, LOAD, CNTVALUEIN[8:0],
//        EN_VTC in; DATAOUT, CNTVALUEOUT[8:0] (committed tap) out.
module idelaye3_asic
    import idelay_pkg::*;
#(
    parameter string DELAY_TYPE  = "VAR_LOAD",
    parameter int    DELAY_VALUE = 0,
    parameter string UPDATE_MODE = "ASYNC",
    parameter string DELAY_SRC   = "IDATAIN"
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IDATAIN,
    input  logic             DATAIN,
    input  logic             CE,
    input  logic             INC,
    input  logic             LOAD,
    input  logic [TAP_W-1:0] CNTVALUEIN,
    input  logic             EN_VTC,
    output logic             DATAOUT,
    output logic [TAP_W-1:0] CNTVALUEOUT
);

    localparam delay_type_e DT =
        (DELAY_TYPE == "FIXED")    ? DT_FIXED    :
        (DELAY_TYPE == "VARIABLE") ? DT_VARIABLE :
                                     DT_VAR_LOAD;

    localparam update_mode_e UM =
        (UPDATE_MODE == "SYNC") ? UM_SYNC : UM_ASYNC;

    localparam delay_src_e DS =
        (DELAY_SRC == "DATAIN") ? SRC_DATAIN : SRC_IDATAIN;

    localparam logic [TAP_W-1:0] RST_TAP = TAP_W'(DELAY_VALUE);

    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] tap_d;
    logic [TAP_W-1:0] pend_q;
    logic [TAP_W-1:0] pend_d;
    logic [TAP_W-1:0] pend_step;
    logic             upd_req;
    logic             src;
    logic             src_edge;
    upd_state_e       st_q;
    upd_state_e       st_d;

    assign src = (DS == SRC_DATAIN) ? DATAIN : IDATAIN;

    // Requested pending tap; LOAD beats CE, both blocked when frozen.
    always_comb begin
        upd_req   = 1'b0;
        pend_step = pend_q;
        if (!EN_VTC && DT != DT_FIXED) begin
            if (LOAD && DT == DT_VAR_LOAD) begin
                upd_req   = 1'b1;
                pend_step = CNTVALUEIN;
            end else if (CE) begin
                upd_req   = 1'b1;
                pend_step = tap_step(pend_q, INC);
            end
        end
    end

    // ASYNC commits at once. SYNC parks the value in ARMED and commits it
    // on the first source transition; a new request while ARMED only
    // replaces the pending value and keeps waiting.
    always_comb begin
        st_d   = st_q;
        pend_d = pend_q;
        tap_d  = tap_q;
        if (UM == UM_ASYNC) begin
            st_d = ST_IDLE;
            if (upd_req) begin
                pend_d = pend_step;
                tap_d  = pend_step;
            end
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    if (upd_req) begin
                        pend_d = pend_step;
                        st_d   = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (upd_req) begin
                        pend_d = pend_step;
                    end else if (src_edge) begin
                        tap_d = pend_q;
                        st_d  = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tap_q  <= RST_TAP;
            pend_q <= RST_TAP;
            st_q   <= ST_IDLE;
        end else begin
            tap_q  <= tap_d;
            pend_q <= pend_d;
            st_q   <= st_d;
        end
    end

    assign CNTVALUEOUT = tap_q;

    idelay_line u_line (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .src      (src),
        .idx      (tap_q[TAP_W-1 -: IDX_W]),
        .dout     (DATAOUT),
        .src_edge (src_edge)
    );

endmodule

// File: tb/tb_idelaye3_asic.sv
// Scoreboard bench for idelaye3_asic across four parameter sets.
// Driver pushes model predictions; a monitor pops and compares each cycle.
module tb_idelaye3_asic;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       IDATAIN = 1'b0;
    logic       DATAIN = 1'b0;
    logic       CE = 1'b0;
    logic       INC = 1'b0;
    logic       LOAD = 1'b0;
    logic       EN_VTC = 1'b0;
    logic [8:0] CNTVALUEIN = '0;

    logic [3:0][8:0] cnt;
    logic [3:0]      dout;

    always #5 CLK = ~CLK;

    // 0: VAR_LOAD/ASYNC/IDATAIN/64   1: VAR_LOAD/SYNC/IDATAIN/64
    // 2: VARIABLE/ASYNC/DATAIN/300   3: FIXED/ASYNC/IDATAIN/200
    idelaye3_asic #(.DELAY_TYPE("VAR_LOAD"), .DELAY_VALUE(64),
        .UPDATE_MODE("ASYNC"), .DELAY_SRC("IDATAIN")) u_a (
        .CLK(CLK), .RST_N(RST_N), .IDATAIN(IDATAIN), .DATAIN(DATAIN),
        .CE(CE), .INC(INC), .LOAD(LOAD), .CNTVALUEIN(CNTVALUEIN),
        .EN_VTC(EN_VTC), .DATAOUT(dout[0]), .CNTVALUEOUT(cnt[0]));

    idelaye3_asic #(.DELAY_TYPE("VAR_LOAD"), .DELAY_VALUE(64),
        .UPDATE_MODE("SYNC"), .DELAY_SRC("IDATAIN")) u_s (
        .CLK(CLK), .RST_N(RST_N), .IDATAIN(IDATAIN), .DATAIN(DATAIN),
        .CE(CE), .INC(INC), .LOAD(LOAD), .CNTVALUEIN(CNTVALUEIN),
        .EN_VTC(EN_VTC), .DATAOUT(dout[1]), .CNTVALUEOUT(cnt[1]));

    idelaye3_asic #(.DELAY_TYPE("VARIABLE"), .DELAY_VALUE(300),
        .UPDATE_MODE("ASYNC"), .DELAY_SRC("DATAIN")) u_v (
        .CLK(CLK), .RST_N(RST_N), .IDATAIN(IDATAIN), .DATAIN(DATAIN),
        .CE(CE), .INC(INC), .LOAD(LOAD), .CNTVALUEIN(CNTVALUEIN),
        .EN_VTC(EN_VTC), .DATAOUT(dout[2]), .CNTVALUEOUT(cnt[2]));

    idelaye3_asic #(.DELAY_TYPE("FIXED"), .DELAY_VALUE(200),
        .UPDATE_MODE("ASYNC"), .DELAY_SRC("IDATAIN")) u_f (
        .CLK(CLK), .RST_N(RST_N), .IDATAIN(IDATAIN), .DATAIN(DATAIN),
        .CE(CE), .INC(INC), .LOAD(LOAD), .CNTVALUEIN(CNTVALUEIN),
        .EN_VTC(EN_VTC), .DATAOUT(dout[3]), .CNTVALUEOUT(cnt[3]));

    typedef struct packed {
        logic [3:0][8:0] cnt;
        logic [3:0]      dout;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    bit c_varload[4] = '{1, 1, 0, 0};
    bit c_fixed[4]   = '{0, 0, 0, 1};
    bit c_sync[4]    = '{0, 1, 0, 0};
    bit c_datain[4]  = '{0, 0, 1, 0};
    int c_dv[4]      = '{64, 64, 300, 200};

    // Reference model: sample history list, committed/pending tap numbers.
    int m_com[4];
    int m_pen[4];
    bit m_arm[4];
    bit m_hist[4][16];
    bit m_dout[4];

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_com[i]  = c_dv[i];
            m_pen[i]  = c_dv[i];
            m_arm[i]  = 1'b0;
            m_dout[i] = 1'b0;
            for (int k = 0; k < 16; k++) m_hist[i][k] = 1'b0;
        end
    endfunction

    function automatic void model_clock();
        for (int i = 0; i < 4; i++) begin
            bit s;
            bit req;
            int np;
            s   = c_datain[i] ? DATAIN : IDATAIN;
            req = 1'b0;
            np  = m_pen[i];
            if (!EN_VTC && !c_fixed[i]) begin
                if (LOAD && c_varload[i]) begin
                    req = 1'b1;
                    np  = int'(CNTVALUEIN);
                end else if (CE) begin
                    req = 1'b1;
                    np  = (m_pen[i] + (INC ? 1 : 511)) % 512;
                end
            end
            m_dout[i] = m_hist[i][m_com[i] / 32];
            if (!c_sync[i]) begin
                if (req) begin
                    m_pen[i] = np;
                    m_com[i] = np;
                end
            end else if (req) begin
                m_pen[i] = np;
                m_arm[i] = 1'b1;
            end else if (m_arm[i] && s != m_hist[i][0]) begin
                m_com[i] = m_pen[i];
                m_arm[i] = 1'b0;
            end
            for (int k = 15; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = s;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.cnt[i]  = 9'(m_com[i]);
            e.dout[i] = m_dout[i];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock: predict the post-edge outputs, then let the edge happen.
    task automatic tick();
        if (!RST_N) model_reset();
        else model_clock();
        sbq.push_back(model_out());
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("async_rst_cnt%0d", i), 32'(cnt[i]), c_dv[i]);
            check($sformatf("async_rst_dout%0d", i), 32'(dout[i]), 0);
        end
        tick();
        RST_N = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("sb_cnt%0d", i), 32'(cnt[i]),
                          32'(e.cnt[i]));
                    check($sformatf("sb_dout%0d", i), 32'(dout[i]),
                          32'(e.dout[i]));
                end
            end
        end
    end

    initial begin : driver
        int lat;
        #2;
        pulse_reset();
        tick();
        check("rst_cnt_after", 32'(cnt[0]), 64);
        check("rst_dout_after", 32'(dout[0]), 0);

        // SYNC: armed value dropped by reset, later edge commits nothing.
        LOAD = 1'b1;
        CNTVALUEIN = 9'd200;
        tick();
        LOAD = 1'b0;
        tick();
        check("sync_armed_hold", 32'(cnt[1]), 64);
        pulse_reset();
        check("sync_rst_val", 32'(cnt[1]), 64);
        IDATAIN = 1'b1;
        tick();
        tick();
        check("sync_rst_discard", 32'(cnt[1]), 64);

        // SYNC: hold while source is steady, commit on first toggle.
        LOAD = 1'b1;
        CNTVALUEIN = 9'd200;
        tick();
        LOAD = 1'b0;
        repeat (4) tick();
        check("sync_hold", 32'(cnt[1]), 64);
        IDATAIN = 1'b0;
        tick();
        check("sync_commit", 32'(cnt[1]), 200);

        // LOAD wins over CE.
        LOAD = 1'b1;
        CE = 1'b1;
        INC = 1'b1;
        CNTVALUEIN = 9'd128;
        tick();
        LOAD = 1'b0;
        CE = 1'b0;
        check("load_priority", 32'(cnt[0]), 128);
        check("fixed_hold", 32'(cnt[3]), 200);

        // Wrap both ways.
        LOAD = 1'b1;
        CNTVALUEIN = 9'd511;
        tick();
        LOAD = 1'b0;
        CE = 1'b1;
        INC = 1'b1;
        tick();
        check("wrap_up", 32'(cnt[0]), 0);
        INC = 1'b0;
        tick();
        check("wrap_down", 32'(cnt[0]), 511);
        CE = 1'b0;

        // Latency at tap 128 (index 4) and VTC freeze.
        LOAD = 1'b1;
        CNTVALUEIN = 9'd128;
        tick();
        LOAD = 1'b0;
        IDATAIN = 1'b0;
        repeat (20) tick();
        check("line_quiet", 32'(dout[0]), 0);
        IDATAIN = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            if (dout[0] === 1'b1) lat = n;
        end
        check("latency_idx4", lat, 6);
        EN_VTC = 1'b1;
        LOAD = 1'b1;
        CNTVALUEIN = 9'd0;
        tick();
        LOAD = 1'b0;
        EN_VTC = 1'b0;
        check("vtc_freeze", 32'(cnt[0]), 128);

        // Randomized traffic.
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                if ($urandom_range(0, 9) < 3) IDATAIN = ~IDATAIN;
                DATAIN     = 1'($urandom);
                CE         = ($urandom_range(0, 9) < 2);
                INC        = 1'($urandom);
                LOAD       = ($urandom_range(0, 9) == 0);
                EN_VTC     = ($urandom_range(0, 5) == 0);
                CNTVALUEIN = 9'($urandom);
                tick();
            end
        end
        CE = 1'b0;
        LOAD = 1'b0;
        tick();
        @(posedge CLK);
        #2;
        check("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
